pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the single-cycle MIPS32 core. It replaces the two-way branch-target selector with a registered PC and a four-way next-PC selector: sequential, conditional branch, absolute jump/call, and return. It adds a stall hold and a circular return-address stack (RAS) for call/return. It sits between instruction fetch and the control/ALU outputs that resolve branches.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/ras_stack.sv | 76 +++++++
 rtl/pc_sequencer.sv | 80 ++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and its return-address stack.
package pc_pkg;

  // Source selected for the next program counter value
  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    RET    = 2'd3
  } pc_sel_t;

  // Default PC loaded on reset
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Ceiling log2, used to size the RAS top pointer
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten when a push
// arrives while full, and a pop from an empty stack only raises a pulse.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             underflow,
  output logic             overflow
);

  localparam int PTR_W = clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic             do_push;
  logic             do_pop;

  assign top_inc  = top + PTR_W'(1);
  assign top_dec  = top - PTR_W'(1);
  assign top_data = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(RAS_DEPTH));
  assign do_pop   = !hold && pop;
  assign do_push  = !hold && push && !pop;

  // Entry storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[top_inc] <= push_data;
    end
  end

  // Top pointer, occupancy count and the one-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      top       <= '0;
      count     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
      if (do_pop) begin
        if (!empty) begin
          top   <= top_dec;
          count <= count - CNT_W'(1);
        end else begin
          underflow <= 1'b1;
        end
      end else if (do_push) begin
        top <= top_inc;
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with a four-way priority next-PC select
// (return, jump/call, taken branch, sequential), stall hold and a RAS.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(PC_RESET_DEFAULT),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             branch_yes,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  input  logic [WIDTH-1:0] ret_fallback,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             ras_overflow
);

  pc_sel_t          sel;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_top;

  assign pc_plus1 = pc + WIDTH'(1);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .push      (call),
    .pop       (ret),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .underflow (ras_underflow),
    .overflow  (ras_overflow)
  );

  // Fixed-priority next-PC source select and target mux
  always_comb begin
    sel     = SEQ;
    next_pc = pc_plus1;
    if (ret) begin
      sel = RET;
    end else if (call || jump) begin
      sel = JUMP;
    end else if (branch && branch_yes) begin
      sel = BRANCH;
    end
    case (sel)
      RET:     next_pc = ras_empty ? ret_fallback : ras_top;
      JUMP:    next_pc = jump_target;
      BRANCH:  next_pc = pc_plus1 + branch_offset;
      default: next_pc = pc_plus1;
    endcase
  end

  // PC register: reset wins, stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes the expected post-edge
// state into a queue, and a monitor pops and compares after every rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        branch_yes = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic        call = 1'b0;
  logic [31:0] jump_target = '0;
  logic        ret = 1'b0;
  logic [31:0] ret_fallback = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_underflow;
  logic        ras_overflow;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        uf;
    logic        of;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  pc_sequencer #(
    .WIDTH     (32),
    .RESET_PC  (32'h100),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .branch_yes    (branch_yes),
    .branch_offset (branch_offset),
    .jump          (jump),
    .call          (call),
    .jump_target   (jump_target),
    .ret           (ret),
    .ret_fallback  (ret_fallback),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow),
    .ras_overflow  (ras_overflow)
  );

  always #5 clk = ~clk;

  // Wait for the falling edge and return every control to its idle value
  task automatic applyStimulus();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; branch = 1'b0; branch_yes = 1'b0;
    branch_offset = '0; jump = 1'b0; call = 1'b0; jump_target = '0;
    ret = 1'b0; ret_fallback = '0;
  endtask

  // Record the state expected after the coming rising edge
  task automatic checkOutput(input string name, input logic [31:0] epc,
                             input logic e, input logic f, input logic uf, input logic of);
    exp_t x;
    x.name = name; x.pc = epc; x.empty = e; x.full = f; x.uf = uf; x.of = of;
    exp_q.push_back(x);
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      if (pc !== x.pc || pc_plus1 !== x.pc + 32'd1 || ras_empty !== x.empty ||
          ras_full !== x.full || ras_underflow !== x.uf || ras_overflow !== x.of) begin
        miscompares++;
        $display("[TB] FAIL %s: got pc=%h pc1=%h e=%b f=%b uf=%b of=%b, want pc=%h pc1=%h e=%b f=%b uf=%b of=%b",
                 x.name, pc, pc_plus1, ras_empty, ras_full, ras_underflow, ras_overflow,
                 x.pc, x.pc + 32'd1, x.empty, x.full, x.uf, x.of);
      end
    end
  end

  // Bound the run in case the stimulus ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(); rst = 1'b1; checkOutput("reset0", 32'h100, 1, 0, 0, 0);
    applyStimulus(); rst = 1'b1; checkOutput("reset1", 32'h100, 1, 0, 0, 0);
    applyStimulus(); checkOutput("free1", 32'h101, 1, 0, 0, 0);
    applyStimulus(); checkOutput("free2", 32'h102, 1, 0, 0, 0);

    applyStimulus(); jump = 1; jump_target = 32'h10; checkOutput("jmp10", 32'h10, 1, 0, 0, 0);
    applyStimulus(); branch = 1; branch_yes = 1; branch_offset = 32'hFFFF_FFFD;
    checkOutput("br_taken", 32'h0E, 1, 0, 0, 0);
    applyStimulus(); jump = 1; jump_target = 32'h10; checkOutput("jmp10b", 32'h10, 1, 0, 0, 0);
    applyStimulus(); branch = 1; branch_yes = 0; branch_offset = 32'hFFFF_FFFD;
    checkOutput("br_nottaken", 32'h11, 1, 0, 0, 0);

    applyStimulus(); jump = 1; jump_target = 32'h20; checkOutput("jmp20", 32'h20, 1, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h30; checkOutput("call1", 32'h30, 0, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h40; checkOutput("call2", 32'h40, 0, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h50; checkOutput("call3", 32'h50, 0, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h60; checkOutput("call4_full", 32'h60, 0, 1, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h70; checkOutput("call5_ovf", 32'h70, 0, 1, 0, 1);
    applyStimulus(); ret = 1; ret_fallback = 32'hDEAD; checkOutput("ret1", 32'h61, 0, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hDEAD; checkOutput("ret2", 32'h51, 0, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hDEAD; checkOutput("ret3", 32'h41, 0, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hDEAD; checkOutput("ret4", 32'h31, 1, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hDEAD; checkOutput("ret5_unf", 32'hDEAD, 1, 0, 1, 0);
    applyStimulus(); checkOutput("unf_cleared", 32'hDEAE, 1, 0, 0, 0);

    applyStimulus(); jump = 1; jump_target = 32'h20; checkOutput("jmp20b", 32'h20, 1, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h90; checkOutput("call_one", 32'h90, 0, 0, 0, 0);
    applyStimulus(); call = 1; ret = 1; jump_target = 32'h55; ret_fallback = 32'hDEAD;
    checkOutput("call_ret", 32'h21, 1, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hBEEF; checkOutput("no_push", 32'hBEEF, 1, 0, 1, 0);
    applyStimulus(); stall = 1; jump = 1; jump_target = 32'h77; checkOutput("stall_jmp", 32'hBEEF, 1, 0, 0, 0);
    applyStimulus(); stall = 1; call = 1; jump_target = 32'h88; checkOutput("stall_call", 32'hBEEF, 1, 0, 0, 0);
    applyStimulus(); stall = 1; ret = 1; ret_fallback = 32'h99; checkOutput("stall_ret", 32'hBEEF, 1, 0, 0, 0);

    applyStimulus(); jump = 1; jump_target = 32'hFFFF_FFFF; checkOutput("jmp_max", 32'hFFFF_FFFF, 1, 0, 0, 0);
    applyStimulus(); checkOutput("wrap", 32'h0, 1, 0, 0, 0);

    applyStimulus(); jump = 1; jump_target = 32'h200; checkOutput("jmp200", 32'h200, 1, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h300; checkOutput("callA", 32'h300, 0, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h400; checkOutput("callB", 32'h400, 0, 0, 0, 0);
    applyStimulus(); call = 1; jump_target = 32'h500; checkOutput("callC", 32'h500, 0, 0, 0, 0);
    applyStimulus(); rst = 1; call = 1; jump_target = 32'h600; checkOutput("rst_mid", 32'h100, 1, 0, 0, 0);
    applyStimulus(); ret = 1; ret_fallback = 32'hCAFE; checkOutput("ret_after_rst", 32'hCAFE, 1, 0, 1, 0);

    applyStimulus();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
